// File: rtl/stream_packet_scheduler.sv
// Packet-atomic weighted round-robin merge of two AXI-Stream sources; optional stats via STREAM_SCHED_STATS_EN.
// Latency: 1 cycle from accepted input beat to registered output beat.
// Backpressure: the granted port sees tready only while the output slot is free; the other port is held off.
module stream_packet_scheduler #(
    parameter int DATA_W  = 64,
    parameter int WEIGHT0 = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_axis0_tdata,
    input  logic              s_axis0_tvalid,
    input  logic              s_axis0_tlast,
    output logic              s_axis0_tready,
    input  logic [DATA_W-1:0] s_axis1_tdata,
    input  logic              s_axis1_tvalid,
    input  logic              s_axis1_tlast,
    output logic              s_axis1_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
`ifdef STREAM_SCHED_STATS_EN
    output logic [15:0]       pkt_cnt0,
    output logic [15:0]       pkt_cnt1,
`endif
    output logic [1:0]        grant
);

    localparam int CW = $clog2(WEIGHT0 + 1);
    localparam logic [CW-1:0] W0 = CW'(WEIGHT0);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     credit_q, credit_d;
    logic [1:0]        grant_q, grant_d;
    logic [DATA_W-1:0] tdata_q, tdata_d;
    logic              tvalid_q, tvalid_d;
    logic              tlast_q, tlast_d;
    logic              slot_free, sel0, sel1, acc0, acc1;

    always_comb begin
        slot_free = !tvalid_q || m_axis_tready;
        sel0      = 1'b0;
        sel1      = 1'b0;
        state_d   = state_q;
        credit_d  = credit_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        grant_d   = 2'b00;

        case (state_q)
            IDLE: begin
                if (s_axis0_tvalid && !s_axis1_tvalid) begin
                    sel0 = 1'b1;
                end else if (!s_axis0_tvalid && s_axis1_tvalid) begin
                    sel1 = 1'b1;
                end else if (s_axis0_tvalid && s_axis1_tvalid) begin
                    if (credit_q < W0) sel0 = 1'b1;
                    else               sel1 = 1'b1;
                end
            end
            LOCK0:   sel0 = 1'b1;
            LOCK1:   sel1 = 1'b1;
            default: ;
        endcase

        // Readies are also gated by reset so nothing is handed over while it is held.
        s_axis0_tready = sel0 && slot_free && !rst;
        s_axis1_tready = sel1 && slot_free && !rst;
        acc0 = s_axis0_tready && s_axis0_tvalid;
        acc1 = s_axis1_tready && s_axis1_tvalid;

        case (state_q)
            IDLE: begin
                if (acc0) begin
                    if (!s_axis1_tvalid)  credit_d = '0;
                    else if (credit_q < W0) credit_d = credit_q + CW'(1);
                    if (!s_axis0_tlast) state_d = LOCK0;
                end
                if (acc1) begin
                    credit_d = '0;
                    if (!s_axis1_tlast) state_d = LOCK1;
                end
            end
            LOCK0:   if (acc0 && s_axis0_tlast) state_d = IDLE;
            LOCK1:   if (acc1 && s_axis1_tlast) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // While idling, the visible grant is this cycle's arbitration decision.
        case (state_d)
            LOCK0:   grant_d = 2'b01;
            LOCK1:   grant_d = 2'b10;
            default: grant_d = (state_q == IDLE) ? {sel1, sel0} : 2'b00;
        endcase

        if (acc0) begin
            tdata_d  = s_axis0_tdata;
            tvalid_d = 1'b1;
            tlast_d  = s_axis0_tlast;
        end else if (acc1) begin
            tdata_d  = s_axis1_tdata;
            tvalid_d = 1'b1;
            tlast_d  = s_axis1_tlast;
        end else if (m_axis_tready) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            credit_q <= '0;
            grant_q  <= 2'b00;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            grant_q  <= grant_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign grant         = grant_q;

`ifdef STREAM_SCHED_STATS_EN
    logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (acc0 && s_axis0_tlast) cnt0_d = cnt0_q + 16'd1;
        if (acc1 && s_axis1_tlast) cnt1_d = cnt1_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign pkt_cnt0 = cnt0_q;
    assign pkt_cnt1 = cnt1_q;
`endif

endmodule
